// File: rtl/regfile_pkg.sv
// Shared sizing constants and operand typedefs for the datapath register file.
// These constants supply the default configuration used by regfile and regfile_rdport.
package regfile_pkg;
  localparam int RF_DATA_W = 8;
  localparam int RF_REG_N  = 8;
  localparam int RF_ADDR_W = 3;

  typedef logic [RF_ADDR_W-1:0] addr_t;
  typedef logic [RF_DATA_W-1:0] data_t;
endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: address mux, register-0 zero force, optional write-through.
// Read latency is zero. This is a pure mux with no flow control.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int REG_N  = RF_REG_N,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [REG_N-1:0][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]            ra_i,
  input  logic [ADDR_W-1:0]            wa_i,
  input  logic [DATA_W-1:0]            wd_i,
  input  logic                         we_i,
  input  logic                         rst_i,
  output logic [DATA_W-1:0]            rd_o
);

  logic fwd;

  // ra_i != 0 is already implied on the forwarding path, so no separate wa_i != 0 term is needed.
  assign fwd = (BYPASS != 0) && we_i && !rst_i && (wa_i == ra_i);

  always_comb begin
    rd_o = regs_i[ra_i];
    if (ra_i == '0) begin
      rd_o = '0;
    end else if (fwd) begin
      rd_o = wd_i;
    end
  end

endmodule

// File: rtl/regfile.sv
// REG_N x DATA_W register file: two combinational read ports, one write port, r0 reads zero.
// Writes land one edge later and reads take zero cycles. It accepts one write every cycle.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int REG_N  = RF_REG_N,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              WE,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  logic [REG_N-1:0][DATA_W-1:0] regs_q;
  logic [REG_N-1:0][DATA_W-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (WE && (WA != '0)) begin
      regs_d[WA] = WD;
    end
    regs_d[0] = '0;
  end

  // Reset dominates any write that is presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_rdport #(
    .DATA_W(DATA_W), .REG_N(REG_N), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
  ) u_rd1 (
    .regs_i(regs_q), .ra_i(RA1), .wa_i(WA), .wd_i(WD),
    .we_i(WE), .rst_i(rst), .rd_o(RD1)
  );

  regfile_rdport #(
    .DATA_W(DATA_W), .REG_N(REG_N), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
  ) u_rd2 (
    .regs_i(regs_q), .ra_i(RA2), .wa_i(WA), .wd_i(WD),
    .we_i(WE), .rst_i(rst), .rd_o(RD2)
  );

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile. It drives the BYPASS=1 and BYPASS=0 builds side by side from shared stimulus.
// A reference array predicts the read data of every port before each clock edge.
module tb_regfile;
  import regfile_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] RA1, RA2, WA;
  logic [7:0] WD;
  logic       WE;
  logic [7:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int errors = 0;
  int checks = 0;

  logic [7:0] mdl [8];

  typedef struct {
    string      tag;
    logic [7:0] b1, b2, n1, n2;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  regfile #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .WA(WA), .WD(WD), .WE(WE),
    .RD1(rd1_b), .RD2(rd2_b)
  );

  regfile #(.BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .WA(WA), .WD(WD), .WE(WE),
    .RD1(rd1_n), .RD2(rd2_n)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The inputs are driven just after a posedge. The expectations are pushed and then checked at the negedge.
  // The model commits the cycle's write at the following posedge.
  task automatic step(input logic r, input logic w, input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] a1, input logic [2:0] a2, input string tag);
    exp_t e;
    rst = r; WE = w; WA = wa; WD = wd; RA1 = a1; RA2 = a2;
    e.tag = tag;
    e.n1  = (a1 == 3'd0) ? 8'h00 : mdl[a1];
    e.n2  = (a2 == 3'd0) ? 8'h00 : mdl[a2];
    e.b1  = (!r && w && wa != 3'd0 && wa == a1) ? wd : e.n1;
    e.b2  = (!r && w && wa != 3'd0 && wa == a2) ? wd : e.n2;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".byp.rd1"}, rd1_b, e.b1);
    chk({e.tag, ".byp.rd2"}, rd2_b, e.b2);
    chk({e.tag, ".nobyp.rd1"}, rd1_n, e.n1);
    chk({e.tag, ".nobyp.rd2"}, rd2_n, e.n2);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    end else if (w && wa != 3'd0) begin
      mdl[wa] = wd;
    end
    #1;
  endtask

  task automatic wr(input logic [2:0] wa, input logic [7:0] wd);
    step(1'b0, 1'b1, wa, wd, 3'd0, 3'd0, "wr");
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), tag);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;

    // Initial reset. Only r0 is read until the array is known.
    step(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, "rst0");
    read_all("post_rst0");

    // Fill every register with 0xFF and then reset. The pre-edge read during the reset cycle still sees 0xFF.
    for (int i = 1; i < 8; i++) wr(3'(i), 8'hFF);
    step(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd7, "rst_full");
    read_all("post_rst");

    // Basic write and read, then feed the operands to AND and OR.
    wr(3'd3, 8'hA5);
    wr(3'd5, 8'h3C);
    step(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd5, "rd35");
    RA1 = 3'd3; RA2 = 3'd5; #1;
    chk("alu_and", rd1_b & rd2_b, 8'h24);
    chk("alu_or", rd1_b | rd2_b, 8'hBD);

    // A write to r0 is dropped and must leave every other register as it was.
    step(1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, "wr_r0");
    read_all("after_r0");

    // Write-through on both ports at once.
    wr(3'd2, 8'h11);
    step(1'b0, 1'b1, 3'd2, 8'h99, 3'd2, 3'd2, "byp_same");
    step(1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2, "byp_after");

    // Reset and write in the same cycle. The write is lost and is not forwarded.
    wr(3'd4, 8'h55);
    step(1'b1, 1'b1, 3'd4, 8'h77, 3'd4, 3'd4, "rst_vs_wr");
    step(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4, "rst_vs_wr_after");

    // Random traffic with an occasional reset.
    for (int n = 0; n < 1000; n++) begin
      step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
